// File: rtl/xga_timing_if.sv
// Video timing bundle from the XGA timing generator to the scaler and colorizer.
// The master drives the bundle; the slave side is the downstream consumer.
interface xga_timing_if;
  logic        horiz_sync;
  logic        vert_sync;
  logic        video_on;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        frame_tick;

  modport master (
    output horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_tick
  );

  modport slave (
    input horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_tick
  );
endinterface

// File: rtl/xga_timing_gen.sv
// 1024x768 display timing generator: counters plus registered sync/position decode.
// Optional start-of-frame pulse is enabled by defining XGA_TIMING_FRAME_TICK_EN.
module xga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  xga_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VISIBLE    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VISIBLE    = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ACTIVE  = 1'(SYNC_POL);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  // Raster position: the line counter advances only when the pixel counter wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else begin
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end
    end
  end

  // Every output is decoded from the same counter snapshot, so position, sync and
  // video_on stay aligned one clock behind the counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vid.pixel_row    <= 12'd0;
      vid.pixel_column <= 12'd0;
      vid.video_on     <= 1'b0;
      vid.horiz_sync   <= ~SYNC_ACTIVE;
      vid.vert_sync    <= ~SYNC_ACTIVE;
    end else begin
      vid.pixel_row    <= v_cnt;
      vid.pixel_column <= h_cnt;
      vid.video_on     <= (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
      vid.horiz_sync   <= ((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END)) ?
                          SYNC_ACTIVE : ~SYNC_ACTIVE;
      vid.vert_sync    <= ((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END)) ?
                          SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

`ifdef XGA_TIMING_FRAME_TICK_EN
  logic frame_wrap;

  // frame_wrap marks the edge where both counters wrapped; delaying it once lines
  // the pulse up with the (0,0) outputs, and reset alone never produces one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_wrap     <= 1'b0;
      vid.frame_tick <= 1'b0;
    end else begin
      frame_wrap     <= h_wrap && (v_cnt == V_LAST);
      vid.frame_tick <= frame_wrap;
    end
  end
`else
  assign vid.frame_tick = 1'b0;
`endif

endmodule

// File: doc/xga_timing_gen.md
Name: xga_timing_gen

Overview:
Display timing generator for the 1024x768 video path. Produces the pixel_row / pixel_column / video_on triple consumed by the map-scaling stage, plus horizontal and vertical sync for the VGA connector. Runs on the 65 MHz pixel clock and sits directly upstream of the scaler and the colorizer.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch, in pixels
H_SYNC, 136, horizontal sync width, in pixels
H_BP, 160, horizontal back porch, in pixels
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch, in lines
V_SYNC, 6, vertical sync width, in lines
V_BP, 29, vertical back porch, in lines
SYNC_POL, 0, active level of both syncs (0 = active-low, XGA standard)

Ports:
clock  input  1  pixel clock, 65 MHz
reset_n  input  1  synchronous, active-low reset
horiz_sync  output  1  horizontal sync, active level SYNC_POL
vert_sync  output  1  vertical sync, active level SYNC_POL
video_on  output  1  high only inside the visible 1024x768 region
pixel_row  output  12  current line, 0..V_TOTAL-1
pixel_column  output  12  current pixel within line, 0..H_TOTAL-1
frame_tick  output  1  one-cycle pulse at start of frame (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806.
- Reset is decided as: one clock; synchronous, active-low reset_n.
- Internal counters: h_cnt (12b) and v_cnt (12b).
- h_cnt increments every clock and wraps from H_TOTAL-1 to 0.
- v_cnt increments only on the h_cnt wrap and wraps from V_TOTAL-1 to 0. On the final pixel of the frame, both counters wrap on the same edge.
- All outputs are registered, decoded from the counter values with one clock of latency. pixel_column/pixel_row equal h_cnt/v_cnt delayed by one cycle, so sync, video_on and position stay mutually aligned.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- horiz_sync is at the active level when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. h_cnt in 1048..1183.
- vert_sync is at the active level when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. v_cnt in 771..776. It changes on the same edge as the line wrap.
- Position outputs keep counting during blanking; downstream stages gate on video_on.
- Reset values (while reset_n=0 at a clock edge): h_cnt=0, v_cnt=0, pixel_row=0, pixel_column=0, video_on=0, horiz_sync=vert_sync=~SYNC_POL, frame_tick=0.
- First clock after release: outputs reflect counter (0,0), so video_on=1 and position=(0,0).
- Reset asserted mid-frame restarts timing at (0,0) with no partial-line recovery.
- Widths: counters compare as unsigned 12-bit; parameter sums must stay below 4096.

Optional Feature:
Macro: XGA_TIMING_FRAME_TICK_EN
- Defined: frame_tick is a registered one-cycle pulse, asserted in the same cycle that pixel_row=0 and pixel_column=0 are presented (once per 1344*806 = 1,083,264 clocks). It is not asserted by reset alone; the first pulse follows the first full frame wrap.
- Undefined: frame_tick is tied to 0 and no extra logic is built.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks -> pixel_row=0, pixel_column=0, video_on=0, horiz_sync=1, vert_sync=1. First clock after release -> video_on=1, position (0,0).
- Line timing: run 1344 clocks -> column runs 0..1343 then returns to 0 and row becomes 1. video_on falls when column goes 1023->1024. horiz_sync is low for exactly 136 clocks, starting at column 1048.
- Frame timing: run 806 lines -> vert_sync low exactly for rows 771..776, 6*1344 clocks. video_on=0 for every row >= 768. Row wraps 805->0 on the same edge column wraps 1343->0.
- Mid-frame reset: assert reset_n=0 for 1 clock at row 400, column 700 -> next outputs are row 0, column 0, syncs inactive, video_on=0; timing then restarts cleanly.
- Scaler integration: feed outputs to the map scaler; at row 767, column 1023 -> map address 127*128+127 = 16383. During blanking the address must not change.
- With XGA_TIMING_FRAME_TICK_EN defined: count frame_tick pulses over 3 frames -> exactly 3 pulses, each coincident with (0,0) and 1,083,264 clocks apart. Without the macro, frame_tick stays 0.
